// File: rtl/spi_cmd_reader.sv
// spi_cmd_reader
// SPI master (mode 0) that reads one measurement result per request from the
// frequency-measurement slave. Each frame is: CS low, CLK_DIV-cycle setup,
// CMD_BITS command bits out on MOSI (MSB first), RESP_BITS response bits in
// from MISO (MSB first), CLK_DIV-cycle hold, CS high, and then a CLK_DIV-cycle
// gap before the next request is accepted.
//
// Ports:
//   i_Clk       system clock, rising edge
//   i_Rst       synchronous reset, active high
//   i_Start     request pulse, sampled only while o_Busy=0
//   i_Cmd       command word, latched when the start is accepted
//   o_Busy      high from the cycle after an accepted start until the gap ends
//   o_Done      one-cycle pulse when o_Resp is updated
//   o_Resp      last received response, held until the next o_Done
//   o_SPI_CLK   SCLK, idles low
//   o_SPI_MOSI  serial command out, changes after SCLK falling edges
//   o_SPI_CS    chip select, active low
//   i_SPI_MISO  serial data in, sampled on SCLK falling edges
module spi_cmd_reader #(
    parameter int CLK_DIV   = 4,
    parameter int CMD_BITS  = 8,
    parameter int RESP_BITS = 40
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_Start,
    input  logic [CMD_BITS-1:0]  i_Cmd,
    output logic                 o_Busy,
    output logic                 o_Done,
    output logic [RESP_BITS-1:0] o_Resp,
    output logic                 o_SPI_CLK,
    output logic                 o_SPI_MOSI,
    output logic                 o_SPI_CS,
    input  logic                 i_SPI_MISO
);
    localparam int TOTAL = CMD_BITS + RESP_BITS;
    localparam int BW    = $clog2(TOTAL + 1);
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

    state_t               state;
    logic [DW-1:0]        div_cnt;
    logic [BW-1:0]        bit_cnt;   // SCLK falling edges seen this frame
    logic [CMD_BITS-1:0]  cmd_sr;
    logic [RESP_BITS-1:0] resp_sr;
    logic                 div_wrap;

    assign div_wrap = (div_cnt == DW'(CLK_DIV - 1));

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            cmd_sr     <= '0;
            resp_sr    <= '0;
            o_Busy     <= 1'b0;
            o_Done     <= 1'b0;
            o_Resp     <= '0;
            o_SPI_CLK  <= 1'b0;
            o_SPI_MOSI <= 1'b0;
            o_SPI_CS   <= 1'b1;
        end else begin
            o_Done <= 1'b0;
            // Half-period counter free-runs in every state but IDLE; each
            // state acts only on the wrap.
            if (state != IDLE)
                div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (i_Start) begin
                        cmd_sr     <= i_Cmd;
                        o_SPI_MOSI <= i_Cmd[CMD_BITS-1];
                        o_SPI_CS   <= 1'b0;
                        o_Busy     <= 1'b1;
                        div_cnt    <= '0;
                        bit_cnt    <= '0;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_wrap)
                        state <= XFER;
                end
                XFER: begin
                    if (div_wrap) begin
                        o_SPI_CLK <= ~o_SPI_CLK;
                        if (o_SPI_CLK) begin
                            // Falling edge number bit_cnt+1.
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt < BW'(CMD_BITS)) begin
                                // Zero fill means the last command shift
                                // leaves MOSI at 0.
                                cmd_sr     <= cmd_sr << 1;
                                o_SPI_MOSI <= cmd_sr[CMD_BITS-2];
                            end else begin
                                resp_sr <= {resp_sr[RESP_BITS-2:0], i_SPI_MISO};
                            end
                            if (bit_cnt == BW'(TOTAL - 1))
                                state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (div_wrap) begin
                        o_SPI_CS <= 1'b1;
                        o_Resp   <= resp_sr;
                        o_Done   <= 1'b1;
                        state    <= GAP;
                    end
                end
                GAP: begin
                    if (div_wrap) begin
                        o_Busy  <= 1'b0;
                        bit_cnt <= '0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_cmd_reader.sv
// Directed bench for spi_cmd_reader: default instance (CLK_DIV=4, 40-bit
// response) plus a small instance (CLK_DIV=2, 16-bit response), each with a
// slave model that drives MISO on SCLK rising edges.
module tb_spi_cmd_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  cmd = 8'h00;
    logic        busy, done, sclk, mosi, cs;
    logic        miso = 1'b0;
    logic [39:0] resp;

    logic        b_start = 1'b0;
    logic [7:0]  b_cmd = 8'h00;
    logic        b_busy, b_done, b_sclk, b_mosi, b_cs;
    logic        b_miso = 1'b0;
    logic [15:0] b_resp;

    spi_cmd_reader #(.CLK_DIV(4), .CMD_BITS(8), .RESP_BITS(40)) dut_a (
        .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_Cmd(cmd),
        .o_Busy(busy), .o_Done(done), .o_Resp(resp),
        .o_SPI_CLK(sclk), .o_SPI_MOSI(mosi), .o_SPI_CS(cs), .i_SPI_MISO(miso)
    );

    spi_cmd_reader #(.CLK_DIV(2), .CMD_BITS(8), .RESP_BITS(16)) dut_b (
        .i_Clk(clk), .i_Rst(rst), .i_Start(b_start), .i_Cmd(b_cmd),
        .o_Busy(b_busy), .o_Done(b_done), .o_Resp(b_resp),
        .o_SPI_CLK(b_sclk), .o_SPI_MOSI(b_mosi), .o_SPI_CS(b_cs), .i_SPI_MISO(b_miso)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave A: captures the command on rises 1..8, then presents response
    // bit (48-r) on rise r so the master samples it on the following fall.
    int          a_rise = 0;
    logic [7:0]  a_mcap = 8'h00;
    logic [39:0] a_rval = 40'h0;
    always @(posedge sclk or negedge cs) begin
        if (sclk) begin
            a_rise = a_rise + 1;
            if (a_rise <= 8) begin
                a_mcap = {a_mcap[6:0], mosi};
            end else if (a_rise <= 48) begin
                a_rval = (a_mcap == 8'd1) ? 40'hA5_1234_5678 :
                         (a_mcap == 8'd2) ? 40'h00_FFFF_0001 : 40'h0;
                miso = a_rval[48 - a_rise];
            end
        end else begin
            a_rise = 0;
            a_mcap = 8'h00;
        end
    end

    // Slave B: fixed 16-bit pattern regardless of command.
    int          b_rise = 0;
    logic [7:0]  b_mcap = 8'h00;
    logic [15:0] b_pat = 16'hC3A5;
    always @(posedge b_sclk or negedge b_cs) begin
        if (b_sclk) begin
            b_rise = b_rise + 1;
            if (b_rise <= 8)
                b_mcap = {b_mcap[6:0], b_mosi};
            else if (b_rise <= 24)
                b_miso = b_pat[24 - b_rise];
        end else begin
            b_rise = 0;
            b_mcap = 8'h00;
        end
    end

    // Runs one frame on DUT A. Called at a negedge; cycle n is the n-th
    // negedge after the accepting clock edge. Extra start pulses at x1/x2.
    task automatic frame_a(input logic [7:0] c, input int x1, input int x2,
                           input logic [39:0] prev,
                           output int t_done, output int t_idle, output int nd,
                           output int nrise, output int cs_hi, output int hold_bad,
                           output logic [39:0] r);
        logic ps;
        ps = sclk;
        t_done = 0; t_idle = 0; nd = 0; nrise = 0; cs_hi = 0; hold_bad = 0; r = '0;
        start = 1'b1;
        cmd   = c;
        for (int n = 1; n <= 1000; n++) begin
            @(negedge clk);
            start = (n == x1) || (n == x2);
            if (n == 1) begin
                chk("cs_low_cycle1", cs, 0);
                chk("busy_cycle1", busy, 1);
            end
            if (sclk && !ps) nrise++;
            ps = sclk;
            if (done) begin
                nd++;
                t_done = n;
                r = resp;
            end else if (nd == 0 && resp !== prev) begin
                hold_bad++;
            end
            if (nd > 0 && cs) cs_hi++;
            if (!busy) begin
                t_idle = n;
                break;
            end
        end
        start = 1'b0;
        if (t_idle == 0) chk("frame_a_timeout", 0, 1);
    endtask

    int          t_done, t_idle, nd, nrise, cs_hi, hold_bad, nchg;
    logic [39:0] r;
    logic        ps;

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cs", cs, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_resp", resp, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        nchg = 0;
        ps = sclk;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sclk !== ps || cs !== 1'b1) nchg++;
            ps = sclk;
        end
        chk("idle_no_sclk", nchg, 0);

        // Single read of result A
        frame_a(8'h01, 0, 0, 40'h0, t_done, t_idle, nd, nrise, cs_hi, hold_bad, r);
        chk("a1_mosi_cmd", a_mcap, 8'h01);
        chk("a1_sclk_periods", nrise, 48);
        chk("a1_done_cycle", t_done, 393);
        chk("a1_done_count", nd, 1);
        chk("a1_resp", r, 40'hA5_1234_5678);
        chk("a1_idle_cycle", t_idle, 397);
        chk("a1_mosi_end", mosi, 0);
        chk("a1_cs_gap_ge4", (cs_hi >= 4), 1);

        // Back-to-back read of result B, started the cycle busy fell
        frame_a(8'h02, 0, 0, 40'hA5_1234_5678, t_done, t_idle, nd, nrise, cs_hi, hold_bad, r);
        chk("a2_mosi_cmd", a_mcap, 8'h02);
        chk("a2_done_cycle", t_done, 393);
        chk("a2_resp", r, 40'h00_FFFF_0001);
        chk("a2_prev_held", hold_bad, 0);

        // Starts while busy are ignored
        frame_a(8'h01, 10, 200, 40'h00_FFFF_0001, t_done, t_idle, nd, nrise, cs_hi, hold_bad, r);
        chk("a3_done_count", nd, 1);
        chk("a3_sclk_periods", nrise, 48);
        chk("a3_done_cycle", t_done, 393);
        chk("a3_resp", r, 40'hA5_1234_5678);
        chk("a3_prev_held", hold_bad, 0);
        nchg = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy || !cs) nchg++;
        end
        chk("a3_no_second_frame", nchg, 0);

        // Reset mid-frame
        start = 1'b1;
        cmd   = 8'h01;
        for (int n = 1; n <= 150; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 150) rst = 1'b1;
        end
        @(negedge clk);
        chk("mid_rst_cs", cs, 1);
        chk("mid_rst_sclk", sclk, 0);
        chk("mid_rst_resp", resp, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_busy", busy, 0);
        rst = 1'b0;
        nchg = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) nchg++;
        end
        chk("mid_rst_no_done", nchg, 0);
        frame_a(8'h01, 0, 0, 40'h0, t_done, t_idle, nd, nrise, cs_hi, hold_bad, r);
        chk("a4_resp", r, 40'hA5_1234_5678);
        chk("a4_done_cycle", t_done, 393);

        // Small instance: CLK_DIV=2, 16-bit response
        t_done = 0; t_idle = 0; nrise = 0;
        ps = b_sclk;
        b_start = 1'b1;
        b_cmd   = 8'h5A;
        for (int n = 1; n <= 500; n++) begin
            @(negedge clk);
            b_start = 1'b0;
            if (b_sclk && !ps) nrise++;
            ps = b_sclk;
            if (b_done) begin
                t_done = n;
                r = {24'h0, b_resp};
            end
            if (!b_busy) begin
                t_idle = n;
                break;
            end
        end
        if (t_idle == 0) chk("b_timeout", 0, 1);
        chk("b_mosi_cmd", b_mcap, 8'h5A);
        chk("b_sclk_periods", nrise, 24);
        chk("b_done_cycle", t_done, 101);
        chk("b_resp", r, 40'h00_0000_C3A5);
        chk("b_idle_cycle", t_idle, 103);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/spi_cmd_reader.md
Name: spi_cmd_reader

Overview:
- SPI master that reads measurement results from the frequency-measurement SPI slave.
- Runs one chip-select frame per request: shifts out a command byte (1 = result A, 2 = result B), then clocks in a RESP_BITS-bit response, MSB first.
- Sits in the host-side/test FPGA and is driven by a controller through a start/done handshake.
- Uses SPI mode 0: SCLK idles low; MOSI changes after falling edges; MISO is sampled on falling edges, because the slave updates MISO on rising edges.

Parameters:
- CLK_DIV, 4, system clocks per SCLK half-period (legal: 2 or more).
- CMD_BITS, 8, command length in bits.
- RESP_BITS, 40, response length in bits.

Ports:
- i_Clk  input  1  system clock; all logic on its rising edge.
- i_Rst  input  1  synchronous reset, active high.
- i_Start  input  1  request pulse; sampled only when o_Busy=0.
- i_Cmd  input  CMD_BITS  command byte; latched when i_Start is accepted.
- o_Busy  output  1  high from the cycle after an accepted start until the inter-frame gap ends.
- o_Done  output  1  one-cycle pulse when o_Resp is updated.
- o_Resp  output  RESP_BITS  last received response; holds until the next o_Done.
- o_SPI_CLK  output  1  SCLK.
- o_SPI_MOSI  output  1  serial command out.
- o_SPI_CS  output  1  chip select, active low.
- i_SPI_MISO  input  1  serial data in.

Behaviour:
- Reset values: o_SPI_CS=1, o_SPI_CLK=0, o_SPI_MOSI=0, o_Busy=0, o_Done=0, o_Resp=0, state=IDLE, all counters 0.
- Reset mid-frame: takes effect on the next edge. CS goes high and SCLK low immediately; no o_Done is issued; o_Resp is cleared.
- TOTAL = CMD_BITS+RESP_BITS SCLK periods per frame. Bit counter is wide enough for TOTAL. Half-period counter counts 0..CLK_DIV-1.
- IDLE:
  - On i_Start=1: latch i_Cmd into the shift register, drive CS=0, drive MOSI=i_Cmd[MSB], set o_Busy=1, go to SETUP.
  - i_Start while o_Busy=1 is ignored; no queueing.
- SETUP:
  - Hold CLK_DIV cycles with CS=0 and SCLK=0, then go to XFER.
- XFER:
  - Toggle SCLK each time the half-period counter wraps.
  - Rising edge: no master action.
  - Falling edge number k (k=1..TOTAL):
    - If k ≤ CMD_BITS: shift the command register and drive its next bit on MOSI; after the last command bit, MOSI=0.
    - If k > CMD_BITS: shift i_SPI_MISO into the response shift register LSB; after RESP_BITS samples the first response bit is at the MSB.
  - After falling edge TOTAL, go to HOLD.
- HOLD:
  - CLK_DIV cycles with CS=0 and SCLK=0.
  - Then drive CS=1, load o_Resp from the shift register, pulse o_Done for exactly 1 cycle (the same cycle CS first reads 1), go to GAP.
- GAP:
  - CLK_DIV cycles with CS=1, then o_Busy=0 and return to IDLE.
  - Minimum CS-high time is therefore CLK_DIV cycles.
- Timing (start accepted at edge 0):
  - CS low from cycle 1.
  - o_Done in cycle 1+CLK_DIV*(2*TOTAL+2). With defaults: 1+4*98 = 393.
  - o_Busy low from cycle 393+CLK_DIV = 397.
  - A new i_Start is accepted in that same cycle.
- SCLK never glitches: exactly TOTAL rising and TOTAL falling edges per frame, with a 50% duty cycle.
- MOSI is stable for ≥CLK_DIV cycles around every rising edge.
- Command value is opaque: any CMD_BITS value is sent unchanged.

Test Plan:
- Reset check: hold i_Rst 3 cycles, then release -> CS=1, SCLK=0, MOSI=0, o_Resp=0, o_Busy=0, o_Done=0; no SCLK edges for 50 cycles with i_Start=0.
- Single read, defaults: slave model (drives MISO on SCLK rise) returns 40'hA5_1234_5678 for cmd 8'd1; pulse i_Start with i_Cmd=8'h01 ->
  - MOSI bits 00000001 captured on the first 8 rising edges;
  - exactly 48 SCLK periods;
  - o_Done at cycle 393;
  - o_Resp=40'hA512345678;
  - o_Busy low at cycle 397.
- Second command, back-to-back: issue cmd 8'd2 the cycle o_Busy falls (model returns 40'h00_FFFF_0001) -> accepted immediately; o_Resp=40'h00FFFF0001; CS high ≥4 cycles between frames; previous o_Resp held until the new o_Done.
- Start while busy: extra i_Start pulses at cycles 10 and 200 of a frame -> ignored; only one frame and one o_Done.
- Reset mid-frame: assert i_Rst at cycle 150 -> next cycle CS=1, SCLK=0, o_Resp=0, no o_Done; a fresh read afterwards returns the correct data.
- Parameter sweep: CLK_DIV=2, RESP_BITS=16, MISO pattern 16'hC3A5 -> o_Resp=16'hC3A5; o_Done at 1+2*(2*24+2) = 101.
